bep_frame_capture: RTL and testbench
====================================

# bep_frame_capture

Parametrised successor to the fixed-layout serial field decoder. It consumes the recovered bit stream from the Manchester state machine and assembles a frame of FRAME_BITS bits, MSB first. Framing comes either from an external start strobe or from a sliding-window preamble hunt. Each complete frame is validated against the preamble and a known-constant mask, and only validated frames are published into a double-buffered output register; the display path reads that register. Rejected frames, aborted frames and inter-bit timeouts are counted.

## Interface
- FRAME_BITS, 192: total bits per frame.
- PREAMBLE_BITS, 32: width of the leading preamble field (≤ FRAME_BITS).
- PREAMBLE, 32'hFFFF_FFFF: required preamble value (PREAMBLE_BITS wide).
- PREAMBLE_SYNC, 1: 1 means frames start on a preamble match in the bit stream; 0 means frames start on `frame_start`.
- CHECK_MASK, 0: FRAME_BITS-wide mask of frame bits that must equal CHECK_VALUE.
- CHECK_VALUE, 0: FRAME_BITS-wide expected value under CHECK_MASK.
- TIMEOUT_CYCLES, 4096: maximum clock cycles between consecutive `bit_valid` pulses while capturing.
- ERR_W, 8: width of each counter.

Ports:
- clock  in  1  system clock; one clock domain; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_valid  in  1  one-cycle strobe; `bit_data` is a new bit.
- bit_data  in  1  recovered data bit.
- frame_start  in  1  one-cycle start strobe. Used only when PREAMBLE_SYNC=0; otherwise ignored.
- frame_out  out  FRAME_BITS  last validated frame; bit FRAME_BITS-1 is the first bit received.
- frame_valid  out  1  one-cycle pulse; `frame_out` has just been updated.
- frame_error  out  1  one-cycle pulse; a frame was rejected or aborted.
- busy  out  1  high while in CAPTURE.
- ok_count  out  ERR_W  validated frames; saturates.
- err_count  out  ERR_W  rejected, aborted and timed-out frames; saturates.

## Operation
- Reset: state=HUNT. All outputs 0: frame_out, frame_valid, frame_error, busy, ok_count, err_count. The shift register, bit counter, fill counter and timeout counter are cleared.
- HUNT, PREAMBLE_SYNC=1:
  - Each `bit_valid` shifts `bit_data` into the low end of the shift register, and a fill counter increments, saturating at PREAMBLE_BITS.
  - When the fill counter is PREAMBLE_BITS and the low PREAMBLE_BITS of the shift register equal PREAMBLE, go to CAPTURE with bit count = PREAMBLE_BITS.
  - A match is evaluated on the register contents including the bit shifted in that cycle.
- HUNT, PREAMBLE_SYNC=0:
  - `frame_start` goes to CAPTURE with bit count 0 and the shift register cleared.
  - If `bit_valid` coincides with `frame_start`, that bit is stored as the first frame bit (count=1).
- CAPTURE:
  - Each `bit_valid` shifts in a bit and increments the count.
  - When the count reaches FRAME_BITS (on the cycle of the final `bit_valid`), the frame is validated and the state returns to HUNT.
  - Validity requires both conditions:
    - frame[FRAME_BITS-1 -: PREAMBLE_BITS] == PREAMBLE
    - (frame & CHECK_MASK) == (CHECK_VALUE & CHECK_MASK)
  - Valid frame: `frame_out` is loaded, `frame_valid` pulses, `ok_count`+1.
  - Invalid frame: `frame_out` is unchanged, `frame_error` pulses, `err_count`+1.
- Timeout: in CAPTURE, a counter clears on every `bit_valid` and increments otherwise. When it reaches TIMEOUT_CYCLES, the frame is aborted: `frame_error` pulses, `err_count`+1, state=HUNT, fill counter cleared.
- Restart: `frame_start` during CAPTURE (PREAMBLE_SYNC=0) aborts the current frame (`frame_error`, `err_count`+1) and restarts capture in the same cycle, with the same coincident-bit rule as in HUNT.
- Double buffering: `frame_out` changes only on a validated frame, so the display path never sees a partial or rejected frame.
- Counters saturate at 2^ERR_W-1 and do not wrap.
- Widths: bit count is $clog2(FRAME_BITS+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- `frame_valid`, `frame_error`, the `frame_out` update and the counter increments are all registered. They are visible in the cycle after the edge that sampled the final `bit_valid`, abort or timeout, i.e. a latency of 1 cycle.
- `frame_valid` and `frame_error` are never high together, and each is high for exactly 1 cycle.
- `busy` rises the cycle after CAPTURE is entered and falls in the same cycle that `frame_valid`/`frame_error` rises.
- Back-to-back frames: in PREAMBLE_SYNC=1, the `bit_valid` immediately after a frame completes is already hunted. No dead cycles are required.
- `reset` wins over every other input in the same cycle. Reset mid-capture discards the partial frame and does not count an error.

## Test plan
- PREAMBLE_SYNC=1, defaults, CHECK_MASK=0. Drive 5 random bits, then 32'hFFFF_FFFF, then 160 payload bits of 0xA5 repeating, one bit per 8 clocks. Required: one `frame_valid`; `frame_out` = {32'hFFFF_FFFF, payload}; `ok_count`=1; `err_count`=0.
- CHECK_MASK selects bits [159:128], CHECK_VALUE[159:128]=32'h1234_5678. Send a frame with 32'h1234_5679 in that field. Required: `frame_error` pulse; `frame_out` still holds the prior frame; `err_count`=1.
- PREAMBLE_SYNC=0, TIMEOUT_CYCLES=16. Pulse `frame_start`, send 40 bits, then stall 16 cycles. Required: `frame_error` exactly 16 cycles after the last `bit_valid`; `busy`=0 afterwards.
- PREAMBLE_SYNC=0. Assert `frame_start` together with `bit_valid`, then 191 more bits forming a valid frame. Required: `frame_valid`; `frame_out[191]` equals the coincident bit.
- ERR_W=2. Produce 5 bad frames. Required: `err_count` sticks at 3. Then assert `reset` mid-frame. Required: all outputs 0 the next cycle, and no error pulse.

Source files
------------

// File: rtl/bep_frame_capture.sv
// -----------------------------------------------------------------------------
// bep_frame_capture
//
// Assembles a FRAME_BITS-wide frame, MSB first, from the recovered bit stream.
// Framing comes from a sliding preamble hunt (PREAMBLE_SYNC=1) or from an
// external start strobe (PREAMBLE_SYNC=0). Each complete frame is checked
// against the preamble and a constant mask. Only frames that pass are
// published to frame_out, so the display path never sees a partial or
// rejected frame. Rejected, aborted and timed-out frames are counted.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HUNT    | waiting for a preamble match or a frame_start strobe
// CAPTURE | shifting frame bits in, with the inter-bit timeout running
//
// Ports
//   clock        system clock; all logic is on the rising edge
//   reset        synchronous, active-high reset
//   bit_valid    one-cycle strobe; bit_data holds a new bit
//   bit_data     recovered data bit
//   frame_start  start strobe, used only when PREAMBLE_SYNC=0
//   frame_out    last validated frame; bit FRAME_BITS-1 was received first
//   frame_valid  one-cycle pulse; frame_out has just been updated
//   frame_error  one-cycle pulse; a frame was rejected, aborted or timed out
//   busy         high while in CAPTURE
//   ok_count     validated frames, saturating
//   err_count    rejected/aborted/timed-out frames, saturating
// -----------------------------------------------------------------------------
module bep_frame_capture #(
    parameter int                        FRAME_BITS     = 192,
    parameter int                        PREAMBLE_BITS  = 32,
    parameter logic [PREAMBLE_BITS-1:0]  PREAMBLE       = 32'hFFFF_FFFF,
    parameter bit                        PREAMBLE_SYNC  = 1'b1,
    parameter logic [FRAME_BITS-1:0]     CHECK_MASK     = '0,
    parameter logic [FRAME_BITS-1:0]     CHECK_VALUE    = '0,
    parameter int                        TIMEOUT_CYCLES = 4096,
    parameter int                        ERR_W          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    input  logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  busy,
    output logic [ERR_W-1:0]      ok_count,
    output logic [ERR_W-1:0]      err_count
);

    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FILL_W = $clog2(PREAMBLE_BITS + 1);

    localparam logic [CNT_W-1:0]  FRAME_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  PRE_COUNT  = CNT_W'(PREAMBLE_BITS);
    localparam logic [TO_W-1:0]   TO_FULL    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PREAMBLE_BITS);

    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [FILL_W-1:0]     fill_cnt;

    logic [FRAME_BITS-1:0] shift_next;
    logic [FRAME_BITS-1:0] first_bit_reg;
    logic [FILL_W-1:0]     fill_next;
    logic [CNT_W-1:0]      cnt_next;
    logic [TO_W-1:0]       to_next;
    logic                  pre_hit;
    logic                  frame_ok;
    logic                  start_hit;

    // Matches and validation look at the register including this cycle's bit.
    assign shift_next    = {shift_reg[FRAME_BITS-2:0], bit_data};
    assign first_bit_reg = {{(FRAME_BITS-1){1'b0}}, bit_data};
    assign fill_next     = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_W'(1);
    assign cnt_next      = bit_cnt + CNT_W'(1);
    assign to_next       = to_cnt + TO_W'(1);
    assign pre_hit       = (shift_next[PREAMBLE_BITS-1:0] == PREAMBLE);
    assign frame_ok      = (shift_next[FRAME_BITS-1 -: PREAMBLE_BITS] == PREAMBLE) &&
                           ((shift_next & CHECK_MASK) == (CHECK_VALUE & CHECK_MASK));
    assign start_hit     = (PREAMBLE_SYNC == 1'b0) && frame_start;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            fill_cnt    <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
            ok_count    <= '0;
            err_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                HUNT: begin
                    if (start_hit) begin
                        state     <= CAPTURE;
                        busy      <= 1'b1;
                        to_cnt    <= '0;
                        shift_reg <= bit_valid ? first_bit_reg : '0;
                        bit_cnt   <= bit_valid ? CNT_W'(1) : '0;
                    end else if (PREAMBLE_SYNC && bit_valid) begin
                        shift_reg <= shift_next;
                        fill_cnt  <= fill_next;
                        if ((fill_next == FILL_FULL) && pre_hit) begin
                            state   <= CAPTURE;
                            busy    <= 1'b1;
                            bit_cnt <= PRE_COUNT;
                            to_cnt  <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    if (start_hit) begin
                        // Abort the frame in flight and restart in the same cycle.
                        frame_error <= 1'b1;
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        to_cnt    <= '0;
                        shift_reg <= bit_valid ? first_bit_reg : '0;
                        bit_cnt   <= bit_valid ? CNT_W'(1) : '0;
                    end else if (bit_valid) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= cnt_next;
                        to_cnt    <= '0;
                        if (cnt_next == FRAME_FULL) begin
                            state    <= HUNT;
                            busy     <= 1'b0;
                            // A new preamble must be seen in full after each frame.
                            fill_cnt <= '0;
                            if (frame_ok) begin
                                frame_out   <= shift_next;
                                frame_valid <= 1'b1;
                                if (ok_count != '1) ok_count <= ok_count + ERR_W'(1);
                            end else begin
                                frame_error <= 1'b1;
                                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                            end
                        end
                    end else if (to_next == TO_FULL) begin
                        state       <= HUNT;
                        busy        <= 1'b0;
                        fill_cnt    <= '0;
                        to_cnt      <= '0;
                        frame_error <= 1'b1;
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                    end else begin
                        to_cnt <= to_next;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_bep_frame_capture.sv
module tb_bep_frame_capture;

    localparam int FB = 192;
    localparam logic [FB-1:0] MASK1 = {32'h0, 32'hFFFF_FFFF, 128'h0};
    localparam logic [FB-1:0] VAL1  = {32'h0, 32'h1234_5678, 128'h0};
    localparam logic [31:0]   PRE   = 32'hFFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    logic bv = 1'b0, bd = 1'b0, fs = 1'b0;
    int   sel = 0;

    logic [FB-1:0] fo0, fo1, fo2;
    logic fv0, fv1, fv2, fe0, fe1, fe2, by0, by1, by2;
    logic [7:0] ok0, ok1, er0, er1;
    logic [1:0] ok2, er2;

    // inst 0: preamble sync, no mask; inst 1: preamble sync with mask;
    // inst 2: start strobe, short timeout, 2-bit counters
    bep_frame_capture u0 (
        .clock(clock), .reset(reset), .bit_valid(bv && sel == 0), .bit_data(bd),
        .frame_start(fs && sel == 0), .frame_out(fo0), .frame_valid(fv0),
        .frame_error(fe0), .busy(by0), .ok_count(ok0), .err_count(er0));

    bep_frame_capture #(.CHECK_MASK(MASK1), .CHECK_VALUE(VAL1)) u1 (
        .clock(clock), .reset(reset), .bit_valid(bv && sel == 1), .bit_data(bd),
        .frame_start(fs && sel == 1), .frame_out(fo1), .frame_valid(fv1),
        .frame_error(fe1), .busy(by1), .ok_count(ok1), .err_count(er1));

    bep_frame_capture #(.PREAMBLE_SYNC(1'b0), .TIMEOUT_CYCLES(16), .ERR_W(2)) u2 (
        .clock(clock), .reset(reset), .bit_valid(bv && sel == 2), .bit_data(bd),
        .frame_start(fs && sel == 2), .frame_out(fo2), .frame_valid(fv2),
        .frame_error(fe2), .busy(by2), .ok_count(ok2), .err_count(er2));

    logic [FB-1:0] m_out;
    logic m_fv, m_fe, m_busy;
    logic [7:0] m_ok, m_err;

    always_comb begin
        m_out = '0; m_fv = 1'b0; m_fe = 1'b0; m_busy = 1'b0; m_ok = '0; m_err = '0;
        case (sel)
            0: begin m_out = fo0; m_fv = fv0; m_fe = fe0; m_busy = by0; m_ok = ok0; m_err = er0; end
            1: begin m_out = fo1; m_fv = fv1; m_fe = fe1; m_busy = by1; m_ok = ok1; m_err = er1; end
            default: begin m_out = fo2; m_fv = fv2; m_fe = fe2; m_busy = by2;
                           m_ok = {6'b0, ok2}; m_err = {6'b0, er2}; end
        endcase
    end

    // pulse totals for the selected instance
    int fv_tot = 0, fe_tot = 0, both_tot = 0;
    always @(negedge clock) begin
        if (m_fv) fv_tot++;
        if (m_fe) fe_tot++;
        if (m_fv && m_fe) both_tot++;
    end

    // reference model
    logic [FB-1:0] exp_out [3];
    int ok_m [3];
    int err_m [3];
    int sat_m [3] = '{255, 255, 3};
    int checks = 0, errors = 0;

    function automatic logic frame_is_valid(input logic [FB-1:0] f, input int inst);
        logic [FB-1:0] mask;
        mask = (inst == 1) ? MASK1 : '0;
        return (f[FB-1:FB-32] == PRE) && ((f & mask) == (VAL1 & mask));
    endfunction

    task automatic model_frame(input int inst, input logic [FB-1:0] f);
        if (frame_is_valid(f, inst)) begin
            exp_out[inst] = f;
            if (ok_m[inst] < sat_m[inst]) ok_m[inst]++;
        end else begin
            if (err_m[inst] < sat_m[inst]) err_m[inst]++;
        end
    endtask

    task automatic model_abort(input int inst);
        if (err_m[inst] < sat_m[inst]) err_m[inst]++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            exp_out[i] = '0; ok_m[i] = 0; err_m[i] = 0;
        end
    endtask

    function automatic logic [FB-1:0] rand_frame(input logic [31:0] pre);
        logic [FB-1:0] f;
        for (int i = 0; i < FB; i++) f[i] = 1'($urandom_range(0, 1));
        f[FB-1:FB-32] = pre;
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bv = 1'b1; bd = b;
        step();
        bv = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic send_bits(input logic [FB-1:0] f, input int hi, input int lo, input int gap);
        for (int i = hi; i >= lo; i--) send_bit(f[i], gap);
    endtask

    task automatic pulse_start();
        fs = 1'b1; step(); fs = 1'b0;
    endtask

    // start strobe together with the first frame bit, then the remaining bits
    task automatic send_started_frame(input logic [FB-1:0] f);
        fs = 1'b1; bv = 1'b1; bd = f[FB-1];
        step();
        fs = 1'b0; bv = 1'b0;
        send_bits(f, FB-2, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bv = 0; bd = 0; fs = 0; reset = 1'b1;
        step(); step();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checks++;
            if (m_out !== '0 || m_fv !== 1'b0 || m_fe !== 1'b0 || m_busy !== 1'b0 ||
                m_ok !== 8'd0 || m_err !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got out=%0h fv=%b fe=%b busy=%b ok=%0d err=%0d want all 0",
                         s, m_out, m_fv, m_fe, m_busy, m_ok, m_err);
            end
        end
        reset = 1'b0;
        model_clear();
        step();
    endtask

    task automatic test_sync_frame();
        logic [FB-1:0] f;
        logic [7:0] a5 = 8'hA5;
        logic [4:0] lead;
        int fv_s, fe_s;
        sel = 0; #1;
        fv_s = fv_tot; fe_s = fe_tot;
        lead = 5'($urandom_range(0, 31)) & 5'b11110;
        for (int i = 4; i >= 0; i--) send_bit(lead[i], 8);
        f[FB-1:FB-32] = PRE;
        for (int i = 0; i < 160; i++) f[159 - i] = a5[7 - (i % 8)];
        send_bits(f, FB-1, FB-32, 8);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_preamble got %b want 1", m_busy);
        end
        send_bits(f, 159, 0, 8);
        model_frame(0, f);
        step(); step();
        checks++;
        if (fv_tot - fv_s !== 1 || fe_tot - fe_s !== 0) begin
            errors++; $display("FAIL sync_pulses got fv=%0d fe=%0d want 1 0", fv_tot - fv_s, fe_tot - fe_s);
        end
        checks++;
        if (m_out !== exp_out[0]) begin
            errors++; $display("FAIL sync_frame_out got %0h want %0h", m_out, exp_out[0]);
        end
        checks++;
        if (m_ok !== 8'(ok_m[0]) || m_err !== 8'(err_m[0]) || m_busy !== 1'b0) begin
            errors++; $display("FAIL sync_counts got ok=%0d err=%0d busy=%b want %0d %0d 0",
                               m_ok, m_err, m_busy, ok_m[0], err_m[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] f1, f2;
        int fv_s;
        sel = 0; #1;
        fv_s = fv_tot;
        f1 = rand_frame(PRE); f2 = rand_frame(PRE);
        send_bits(f1, FB-1, 0, 1);
        send_bits(f2, FB-1, 0, 1);
        model_frame(0, f1); model_frame(0, f2);
        step(); step();
        checks++;
        if (fv_tot - fv_s !== 2) begin
            errors++; $display("FAIL b2b_valid_pulses got %0d want 2", fv_tot - fv_s);
        end
        checks++;
        if (m_out !== exp_out[0] || m_ok !== 8'(ok_m[0])) begin
            errors++; $display("FAIL b2b_frame got out=%0h ok=%0d want %0h %0d", m_out, m_ok, exp_out[0], ok_m[0]);
        end
    endtask

    task automatic test_check_mask();
        logic [FB-1:0] good, bad;
        int fv_s, fe_s;
        sel = 1; #1;
        fv_s = fv_tot; fe_s = fe_tot;
        good = rand_frame(PRE); good[159:128] = 32'h1234_5678;
        bad  = rand_frame(PRE); bad[159:128]  = 32'h1234_5679;
        send_bits(good, FB-1, 0, 2);
        send_bit(1'b0, 2); send_bit(1'b0, 2);
        send_bits(bad, FB-1, 0, 2);
        model_frame(1, good); model_frame(1, bad);
        step(); step();
        checks++;
        if (fv_tot - fv_s !== 1 || fe_tot - fe_s !== 1) begin
            errors++; $display("FAIL mask_pulses got fv=%0d fe=%0d want 1 1", fv_tot - fv_s, fe_tot - fe_s);
        end
        checks++;
        if (m_out !== exp_out[1]) begin
            errors++; $display("FAIL mask_out_held got %0h want %0h", m_out, exp_out[1]);
        end
        checks++;
        if (m_err !== 8'(err_m[1]) || m_ok !== 8'(ok_m[1])) begin
            errors++; $display("FAIL mask_counts got ok=%0d err=%0d want %0d %0d", m_ok, m_err, ok_m[1], err_m[1]);
        end
    endtask

    task automatic test_random_frames();
        logic [FB-1:0] f;
        int gap, junk;
        sel = 1; #1;
        for (int n = 0; n < 8; n++) begin
            f = rand_frame(PRE);
            if ($urandom_range(0, 1) == 1) f[159:128] = 32'h1234_5678;
            else f[159:128] = 32'h1234_5678 ^ (32'h1 << $urandom_range(0, 31));
            gap = $urandom_range(1, 3);
            junk = $urandom_range(0, 3);
            repeat (junk) send_bit(1'b0, 1);
            send_bits(f, FB-1, 0, gap);
            model_frame(1, f);
            step();
            checks++;
            if (m_out !== exp_out[1] || m_ok !== 8'(ok_m[1]) || m_err !== 8'(err_m[1])) begin
                errors++;
                $display("FAIL random_frame n=%0d got out=%0h ok=%0d err=%0d want %0h %0d %0d",
                         n, m_out, m_ok, m_err, exp_out[1], ok_m[1], err_m[1]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [FB-1:0] f;
        int n;
        sel = 2; #1;
        f = rand_frame(PRE);
        pulse_start();
        send_bits(f, FB-1, FB-40, 1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m_fe === 1'b1) begin n = i; break; end
        end
        model_abort(2);
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL timeout_latency got %0d want 16", n);
        end
        checks++;
        if (m_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_busy got %b want 0", m_busy);
        end
        step();
        checks++;
        if (m_err !== 8'(err_m[2])) begin
            errors++; $display("FAIL timeout_err_count got %0d want %0d", m_err, err_m[2]);
        end
    endtask

    task automatic test_coincident();
        logic [FB-1:0] f, g;
        int fv_s, fe_s;
        sel = 2; #1;
        fv_s = fv_tot; fe_s = fe_tot;
        f = rand_frame(PRE);
        send_started_frame(f);
        model_frame(2, f);
        step();
        checks++;
        if (fv_tot - fv_s !== 1 || m_out !== exp_out[2]) begin
            errors++; $display("FAIL coincident_frame got fv=%0d out=%0h want 1 %0h", fv_tot - fv_s, m_out, exp_out[2]);
        end
        checks++;
        if (m_out[FB-1] !== f[FB-1]) begin
            errors++; $display("FAIL coincident_msb got %b want %b", m_out[FB-1], f[FB-1]);
        end
        g = rand_frame(PRE);
        g[FB-1] = 1'b0;
        send_started_frame(g);
        model_frame(2, g);
        step();
        checks++;
        if (fe_tot - fe_s !== 1 || m_out !== exp_out[2]) begin
            errors++; $display("FAIL coincident_zero got fe=%0d out=%0h want 1 %0h", fe_tot - fe_s, m_out, exp_out[2]);
        end
    endtask

    task automatic test_restart();
        logic [FB-1:0] f;
        int fv_s, fe_s;
        sel = 2; #1;
        fv_s = fv_tot; fe_s = fe_tot;
        f = rand_frame(PRE);
        pulse_start();
        send_bits(rand_frame(PRE), FB-1, FB-50, 1);
        send_started_frame(f);
        model_abort(2);
        model_frame(2, f);
        step();
        checks++;
        if (fe_tot - fe_s !== 1 || fv_tot - fv_s !== 1) begin
            errors++; $display("FAIL restart_pulses got fe=%0d fv=%0d want 1 1", fe_tot - fe_s, fv_tot - fv_s);
        end
        checks++;
        if (m_out !== exp_out[2] || m_err !== 8'(err_m[2])) begin
            errors++; $display("FAIL restart_frame got out=%0h err=%0d want %0h %0d", m_out, m_err, exp_out[2], err_m[2]);
        end
    endtask

    task automatic test_saturation();
        logic [FB-1:0] f;
        int fe_s;
        sel = 2; #1;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            f = rand_frame(32'h7FFF_FFFF ^ (32'h1 << $urandom_range(0, 30)));
            pulse_start();
            send_bits(f, FB-1, 0, 1);
            model_frame(2, f);
            step();
            checks++;
            if (m_err !== 8'(err_m[2])) begin
                errors++; $display("FAIL err_saturation n=%0d got %0d want %0d", n, m_err, err_m[2]);
            end
        end
        pulse_start();
        send_bits(rand_frame(PRE), FB-1, FB-20, 1);
        fe_s = fe_tot;
        reset = 1'b1;
        step();
        model_clear();
        checks++;
        if (m_out !== '0 || m_fv !== 1'b0 || m_fe !== 1'b0 || m_busy !== 1'b0 ||
            m_ok !== 8'd0 || m_err !== 8'd0) begin
            errors++;
            $display("FAIL midframe_reset got out=%0h fv=%b fe=%b busy=%b ok=%0d err=%0d want all 0",
                     m_out, m_fv, m_fe, m_busy, m_ok, m_err);
        end
        reset = 1'b0;
        repeat (30) step();
        checks++;
        if (fe_tot - fe_s !== 0 || m_busy !== 1'b0 || m_err !== 8'(err_m[2])) begin
            errors++; $display("FAIL reset_no_error got fe=%0d busy=%b err=%0d want 0 0 0",
                               fe_tot - fe_s, m_busy, m_err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_sync_frame();
        test_back_to_back();
        test_check_mask();
        test_random_frames();
        test_timeout();
        test_coincident();
        test_restart();
        test_saturation();
        checks++;
        if (both_tot !== 0) begin
            errors++; $display("FAIL valid_error_overlap got %0d want 0", both_tot);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
